// File: rtl/cr_osf_split.sv
// cr_osf_split: separates the merged OSF TLV stream into a data-path stream
// (RQE, DATA, DATA_UNK, LZ77) and a PDT stream (everything else), one whole
// TLV at a time, while tracking command framing for group boundaries.
// Head-word fields: tuser[0]=SOT, tuser[1]=EOT, tdata[7:0]=tlv_type,
// RQE frame_size in tdata[11:8], DATA/DATA_UNK/LZ77 last_of_command in tdata[8].

package cr_osf_split_pkg;

   typedef struct packed {
      logic [63:0] tdata;
      logic [7:0]  tuser;
      logic [7:0]  tstrb;
      logic        tlast;
   } axi4s_dp_bus_t;

   typedef enum logic [7:0] {
      TLV_RQE                = 8'h00,
      TLV_CMD                = 8'h01,
      TLV_KEY                = 8'h02,
      TLV_PHD                = 8'h03,
      TLV_PFD                = 8'h04,
      TLV_DATA_UNK           = 8'h05,
      TLV_FRMD_USER_NULL     = 8'h06,
      TLV_FRMD_USER_PI16     = 8'h07,
      TLV_FRMD_USER_PI64     = 8'h08,
      TLV_FRMD_USER_VM       = 8'h09,
      TLV_FRMD_INT_APP       = 8'h0a,
      TLV_FRMD_INT_SIP       = 8'h0b,
      TLV_FRMD_INT_LIP       = 8'h0c,
      TLV_FRMD_INT_VM        = 8'h0d,
      TLV_FRMD_INT_VM_SHORT  = 8'h0e,
      TLV_DATA               = 8'h0f,
      TLV_CQE                = 8'h10,
      TLV_CR_IV              = 8'h11,
      TLV_AUX_CMD            = 8'h12,
      TLV_LZ77               = 8'h13
   } tlv_type_e;

   typedef enum logic [3:0] {
      RQE_SIMPLE      = 4'd0,
      RQE_COMPOUND_4K = 4'd1,
      RQE_COMPOUND_8K = 4'd2
   } rqe_frame_size_e;

endpackage

module cr_osf_split
   import cr_osf_split_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  axi4s_dp_bus_t      ib_fifo_rdata,
   input  logic               ib_fifo_empty,
   output logic               ib_fifo_rd,
   input  logic               ob_data_fifo_full,
   output logic               ob_data_fifo_wr,
   output axi4s_dp_bus_t      ob_data_fifo_wdata,
   input  logic               ob_pdt_fifo_full,
   output logic               ob_pdt_fifo_wr,
   output axi4s_dp_bus_t      ob_pdt_fifo_wdata,
   output logic               group_done,
   output logic               proto_err,
   output logic [CNT_W-1:0]   data_tlv_cnt,
   output logic [CNT_W-1:0]   pdt_tlv_cnt
);

   typedef enum logic [1:0] {
      SPL_SOT = 2'd0,
      SPL_DF  = 2'd1,
      SPL_PF  = 2'd2
   } spl_state_e;

   spl_state_e state, state_nxt;

   logic [7:0] tlv_type;
   logic [3:0] frame_size;
   logic       sot, eot, last_of_cmd;
   logic       is_data_type, is_cqe, is_frmd;
   logic       dst_data, xfer, err_nxt, gd_nxt, cur_cqe, cur_frmd;
   logic       simp_cmd, cmp_cmd, last_frame, pf_cqe, pf_frmd;

   assign ob_data_fifo_wdata = ib_fifo_rdata;
   assign ob_pdt_fifo_wdata  = ib_fifo_rdata;
   assign tlv_type    = ib_fifo_rdata.tdata[7:0];
   assign frame_size  = ib_fifo_rdata.tdata[11:8];
   assign last_of_cmd = ib_fifo_rdata.tdata[8];
   assign sot         = ib_fifo_rdata.tuser[0];
   assign eot         = ib_fifo_rdata.tuser[1];

   // Classify the head word by TLV type
   always_comb begin
      is_data_type = 1'b0;
      is_cqe       = 1'b0;
      is_frmd      = 1'b0;
      case (tlv_type)
         TLV_RQE, TLV_DATA, TLV_DATA_UNK, TLV_LZ77: is_data_type = 1'b1;
         TLV_CQE: is_cqe = 1'b1;
         TLV_FRMD_USER_NULL, TLV_FRMD_USER_PI16, TLV_FRMD_USER_PI64,
         TLV_FRMD_USER_VM, TLV_FRMD_INT_APP, TLV_FRMD_INT_SIP,
         TLV_FRMD_INT_LIP, TLV_FRMD_INT_VM, TLV_FRMD_INT_VM_SHORT: is_frmd = 1'b1;
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= SPL_SOT;
      else     state <= state_nxt;
   end

   // Destination select, handshake, next state and framing decode.
   // Any SOT word is classified fresh, whatever the state; a non-SOT word
   // seen while idle falls through to PDT.
   always_comb begin
      state_nxt       = state;
      dst_data        = 1'b0;
      xfer            = 1'b0;
      ib_fifo_rd      = 1'b0;
      ob_data_fifo_wr = 1'b0;
      ob_pdt_fifo_wr  = 1'b0;
      err_nxt         = 1'b0;
      cur_cqe         = 1'b0;
      cur_frmd        = 1'b0;
      gd_nxt          = 1'b0;

      if (sot) dst_data = is_data_type;
      else     dst_data = (state == SPL_DF);

      xfer = !rst && !ib_fifo_empty &&
             (dst_data ? !ob_data_fifo_full : !ob_pdt_fifo_full);
      ib_fifo_rd      = xfer;
      ob_data_fifo_wr = xfer && dst_data;
      ob_pdt_fifo_wr  = xfer && !dst_data;

      if (sot) begin
         cur_cqe  = is_cqe;
         cur_frmd = is_frmd;
      end else if (state == SPL_PF) begin
         cur_cqe  = pf_cqe;
         cur_frmd = pf_frmd;
      end

      if (xfer) begin
         if (sot) begin
            err_nxt = (state != SPL_SOT);
            if (eot)           state_nxt = SPL_SOT;
            else if (dst_data) state_nxt = SPL_DF;
            else               state_nxt = SPL_PF;
         end else if (state == SPL_SOT) begin
            err_nxt = 1'b1;
         end else if (eot) begin
            state_nxt = SPL_SOT;
         end
      end

      gd_nxt = xfer && eot &&
               ((cur_cqe && (simp_cmd || (cmp_cmd && last_frame))) ||
                (cur_frmd && cmp_cmd && !last_frame));
   end

   // Command context, PDT type flags, error flag and saturating counters
   always_ff @(posedge clk) begin
      if (rst) begin
         group_done   <= 1'b0;
         proto_err    <= 1'b0;
         simp_cmd     <= 1'b0;
         cmp_cmd      <= 1'b0;
         last_frame   <= 1'b0;
         pf_cqe       <= 1'b0;
         pf_frmd      <= 1'b0;
         data_tlv_cnt <= '0;
         pdt_tlv_cnt  <= '0;
      end else begin
         group_done <= gd_nxt;
         if (err_nxt) proto_err <= 1'b1;
         if (xfer && sot) begin
            if (dst_data) begin
               if (data_tlv_cnt != '1) data_tlv_cnt <= data_tlv_cnt + CNT_W'(1);
            end else begin
               if (pdt_tlv_cnt != '1) pdt_tlv_cnt <= pdt_tlv_cnt + CNT_W'(1);
            end
            if (tlv_type == TLV_RQE) begin
               simp_cmd <= (frame_size == RQE_SIMPLE);
               cmp_cmd  <= (frame_size == RQE_COMPOUND_4K) ||
                           (frame_size == RQE_COMPOUND_8K);
            end
            if (is_data_type && tlv_type != TLV_RQE) last_frame <= last_of_cmd;
         end
         if (gd_nxt) begin
            pf_cqe  <= 1'b0;
            pf_frmd <= 1'b0;
         end else if (xfer && sot) begin
            pf_cqe  <= is_cqe;
            pf_frmd <= is_frmd;
         end
      end
   end

endmodule

// File: tb/tb_cr_osf_split.sv
// Scoreboard bench for cr_osf_split: the driver pushes each expected word onto
// a per-destination queue as it is offered; the monitor pops and compares
// whenever a FIFO write is presented.

module tb_cr_osf_split;
   import cr_osf_split_pkg::*;

   localparam int unsigned CNT_W = 4;

   logic               clk = 1'b0;
   logic               rst;
   axi4s_dp_bus_t      ib_fifo_rdata;
   logic               ib_fifo_empty;
   logic               ib_fifo_rd;
   logic               ob_data_fifo_full;
   logic               ob_data_fifo_wr;
   axi4s_dp_bus_t      ob_data_fifo_wdata;
   logic               ob_pdt_fifo_full;
   logic               ob_pdt_fifo_wr;
   axi4s_dp_bus_t      ob_pdt_fifo_wdata;
   logic               group_done;
   logic               proto_err;
   logic [CNT_W-1:0]   data_tlv_cnt;
   logic [CNT_W-1:0]   pdt_tlv_cnt;

   cr_osf_split #(.CNT_W(CNT_W)) dut (
      .clk                (clk),
      .rst                (rst),
      .ib_fifo_rdata      (ib_fifo_rdata),
      .ib_fifo_empty      (ib_fifo_empty),
      .ib_fifo_rd         (ib_fifo_rd),
      .ob_data_fifo_full  (ob_data_fifo_full),
      .ob_data_fifo_wr    (ob_data_fifo_wr),
      .ob_data_fifo_wdata (ob_data_fifo_wdata),
      .ob_pdt_fifo_full   (ob_pdt_fifo_full),
      .ob_pdt_fifo_wr     (ob_pdt_fifo_wr),
      .ob_pdt_fifo_wdata  (ob_pdt_fifo_wdata),
      .group_done         (group_done),
      .proto_err          (proto_err),
      .data_tlv_cnt       (data_tlv_cnt),
      .pdt_tlv_cnt        (pdt_tlv_cnt)
   );

   always #5 clk = ~clk;

   axi4s_dp_bus_t exp_data[$];
   axi4s_dp_bus_t exp_pdt[$];
   axi4s_dp_bus_t mon_exp;
   int            vectors    = 0;
   int            miscompares = 0;
   int            gd_cnt     = 0;
   int            rd_run     = 0;
   int            max_run    = 0;
   logic [47:0]   seq        = '0;

   // Monitor: sample one time unit before each rising edge
   always @(negedge clk) begin
      #4;
      if (ob_data_fifo_wr) begin
         vectors++;
         if (exp_data.size() == 0) begin
            miscompares++;
            $display("FAIL data_wr: got %h, expected no write", ob_data_fifo_wdata);
         end else begin
            mon_exp = exp_data.pop_front();
            if (ob_data_fifo_wdata !== mon_exp) begin
               miscompares++;
               $display("FAIL data_word: got %h expected %h", ob_data_fifo_wdata, mon_exp);
            end
         end
      end
      if (ob_pdt_fifo_wr) begin
         vectors++;
         if (exp_pdt.size() == 0) begin
            miscompares++;
            $display("FAIL pdt_wr: got %h, expected no write", ob_pdt_fifo_wdata);
         end else begin
            mon_exp = exp_pdt.pop_front();
            if (ob_pdt_fifo_wdata !== mon_exp) begin
               miscompares++;
               $display("FAIL pdt_word: got %h expected %h", ob_pdt_fifo_wdata, mon_exp);
            end
         end
      end
      if (ib_fifo_rd || ob_data_fifo_wr || ob_pdt_fifo_wr) begin
         vectors++;
         if (ib_fifo_rd !== (ob_data_fifo_wr ^ ob_pdt_fifo_wr) || ib_fifo_empty ||
             (ob_data_fifo_wr && ob_data_fifo_full) || (ob_pdt_fifo_wr && ob_pdt_fifo_full)) begin
            miscompares++;
            $display("FAIL handshake: got rd=%b dwr=%b pwr=%b (empty=%b dfull=%b pfull=%b) expected rd = exactly one unblocked wr",
                     ib_fifo_rd, ob_data_fifo_wr, ob_pdt_fifo_wr, ib_fifo_empty,
                     ob_data_fifo_full, ob_pdt_fifo_full);
         end
      end
      if (group_done === 1'b1) gd_cnt++;
      if (ib_fifo_rd === 1'b1) rd_run++;
      else rd_run = 0;
      if (rd_run > max_run) max_run = rd_run;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic axi4s_dp_bus_t mk(input logic [7:0] typ, input logic s,
                                         input logic e, input logic [7:0] hdr);
      axi4s_dp_bus_t w;
      seq = seq + 48'd1;
      w = '0;
      w.tdata = {seq, hdr, typ};
      w.tuser = {6'b0, e, s};
      w.tstrb = '1;
      w.tlast = e;
      return w;
   endfunction

   // Offer one word (called at a falling edge); returns after it is popped
   task automatic put(input axi4s_dp_bus_t w, input logic to_data, output int waits);
      ib_fifo_rdata = w;
      ib_fifo_empty = 1'b0;
      if (to_data) exp_data.push_back(w);
      else         exp_pdt.push_back(w);
      waits = 0;
      #1;
      while (ib_fifo_rd !== 1'b1 && waits < 100) begin
         @(negedge clk);
         #1;
         waits++;
      end
      if (ib_fifo_rd !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL put_timeout: got rd=%b expected 1 within 100 cycles", ib_fifo_rd);
      end
      @(negedge clk);
      ib_fifo_empty = 1'b1;
   endtask

   task automatic send_tlv(input logic [7:0] typ, input logic [7:0] hdr, input int n,
                           input logic to_data);
      int w;
      for (int i = 0; i < n; i++)
         put(mk((i == 0) ? typ : 8'h3C, i == 0, i == n - 1, (i == 0) ? hdr : 8'h5A), to_data, w);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ib_fifo_empty = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      int w;
      rst = 1'b1;
      ib_fifo_empty = 1'b0;
      ib_fifo_rdata = mk(TLV_DATA, 1'b1, 1'b0, 8'h00);
      ob_data_fifo_full = 1'b0;
      ob_pdt_fifo_full  = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rd_gated", {29'd0, ib_fifo_rd, ob_data_fifo_wr, ob_pdt_fifo_wr}, 0);
      chk("rst_state", {group_done, proto_err, 2'b0, 4'(data_tlv_cnt), 4'(pdt_tlv_cnt)}, 0);
      @(negedge clk);
      rst = 1'b0;
      ib_fifo_empty = 1'b1;
      @(negedge clk);

      // Simple command: RQE + DATA + CQE
      max_run = 0;
      send_tlv(TLV_RQE,  8'h00, 2, 1'b1);
      send_tlv(TLV_DATA, 8'h00, 4, 1'b1);
      send_tlv(TLV_CQE,  8'h00, 2, 1'b0);
      #1 chk("gd_after_simple_cqe", group_done, 1);
      repeat (3) @(negedge clk);
      chk("gd_count_simple", gd_cnt, 1);
      chk("rd_run_8", max_run, 8);
      chk("data_cnt_simple", data_tlv_cnt, 2);
      chk("pdt_cnt_simple", pdt_tlv_cnt, 1);

      // Compound 4K command: FRMD closes the mid group, CQE the last
      send_tlv(TLV_RQE,  8'h01, 2, 1'b1);
      send_tlv(TLV_DATA, 8'h00, 3, 1'b1);
      send_tlv(TLV_FRMD_INT_APP, 8'h00, 3, 1'b0);
      #1 chk("gd_after_frmd", group_done, 1);
      send_tlv(TLV_DATA, 8'h01, 2, 1'b1);
      #1 chk("no_gd_after_data", group_done, 0);
      send_tlv(TLV_CQE, 8'h00, 2, 1'b0);
      #1 chk("gd_after_compound_cqe", group_done, 1);
      repeat (3) @(negedge clk);
      chk("gd_count_compound", gd_cnt, 3);

      // PDT backpressure for 5 cycles mid-CQE
      put(mk(TLV_CQE, 1'b1, 1'b0, 8'h00), 1'b0, w);
      ob_pdt_fifo_full = 1'b1;
      fork
         put(mk(8'h3C, 1'b0, 1'b1, 8'h5A), 1'b0, w);
         begin
            repeat (5) @(negedge clk);
            ob_pdt_fifo_full = 1'b0;
         end
      join
      chk("pdt_stall_cycles", w, 5);

      // Data FIFO full must not stall a PDT TLV
      ob_data_fifo_full = 1'b1;
      put(mk(TLV_CQE, 1'b1, 1'b0, 8'h00), 1'b0, w);
      chk("dfull_no_stall_w0", w, 0);
      put(mk(8'h3C, 1'b0, 1'b1, 8'h5A), 1'b0, w);
      chk("dfull_no_stall_w1", w, 0);
      ob_data_fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      chk("gd_count_stall", gd_cnt, 5);
      chk("data_cnt_mid", data_tlv_cnt, 5);
      chk("pdt_cnt_mid", pdt_tlv_cnt, 5);
      chk("no_err_yet", proto_err, 0);

      // Single-word DATA TLV, then SOT=0 while idle
      do_reset();
      chk("rst_cnt_cleared", {4'(data_tlv_cnt), 4'(pdt_tlv_cnt)}, 0);
      send_tlv(TLV_DATA, 8'h00, 1, 1'b1);
      chk("single_data_cnt", data_tlv_cnt, 1);
      chk("single_no_err", proto_err, 0);
      put(mk(TLV_DATA, 1'b0, 1'b0, 8'h00), 1'b0, w);
      chk("idle_nosot_err", proto_err, 1);
      chk("idle_nosot_no_cnt", {4'(data_tlv_cnt), 4'(pdt_tlv_cnt)}, 8'h10);

      // SOT in the middle of a DATA TLV is reclassified
      put(mk(TLV_DATA, 1'b1, 1'b0, 8'h00), 1'b1, w);
      put(mk(TLV_CQE,  1'b1, 1'b1, 8'h00), 1'b0, w);
      send_tlv(TLV_DATA, 8'h00, 1, 1'b1);
      repeat (2) @(negedge clk);
      chk("reclass_cnts", {4'(data_tlv_cnt), 4'(pdt_tlv_cnt)}, 8'h31);
      chk("err_sticky", proto_err, 1);

      // Counter saturation with single-word PDT TLVs
      do_reset();
      chk("rst_clears_err", proto_err, 0);
      for (int i = 0; i < 15; i++) send_tlv(TLV_CMD, 8'h00, 1, 1'b0);
      chk("pdt_cnt_at_max", pdt_tlv_cnt, 15);
      for (int i = 0; i < 4; i++) send_tlv(TLV_CMD, 8'h00, 1, 1'b0);
      chk("pdt_cnt_saturated", pdt_tlv_cnt, 15);
      chk("data_cnt_zero", data_tlv_cnt, 0);

      // Reset mid-TLV abandons it; the continuation word becomes an error
      put(mk(TLV_DATA, 1'b1, 1'b0, 8'h00), 1'b1, w);
      rst = 1'b1;
      ib_fifo_rdata = mk(8'h3C, 1'b0, 1'b1, 8'h5A);
      ib_fifo_empty = 1'b0;
      #1 chk("rst_gates_rd_wr", {29'd0, ib_fifo_rd, ob_data_fifo_wr, ob_pdt_fifo_wr}, 0);
      @(negedge clk);
      #1 chk("rst_mid_tlv_state", {group_done, proto_err, 2'b0, 4'(data_tlv_cnt), 4'(pdt_tlv_cnt)}, 0);
      rst = 1'b0;
      put(ib_fifo_rdata, 1'b0, w);
      chk("post_rst_err", proto_err, 1);
      chk("post_rst_cnts", {4'(data_tlv_cnt), 4'(pdt_tlv_cnt)}, 0);

      repeat (3) @(negedge clk);
      chk("exp_data_drained", exp_data.size(), 0);
      chk("exp_pdt_drained", exp_pdt.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
